i2s_rx_sample_fifo: RTL and testbench
=====================================

I2S_RX_SAMPLE_FIFO -- requirements
Module: i2s_rx_sample_fifo

Interface
REQ-001 Parameter DEPTH, default 8: number of stereo frames stored; SHALL be a power of two, 2..256.
REQ-002 Parameter WIDTH, default 16: bits per channel word.
REQ-003 i2s_bclk  input  1  sole clock; all logic SHALL sample on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 i2s_lrclk  input  1  word select from i2s_master: 0 = left, 1 = right.
REQ-006 left_data_in  input  WIDTH  parallel left word from i2s_master left_data_out.
REQ-007 right_data_in  input  WIDTH  parallel right word from i2s_master right_data_out.
REQ-008 out_valid  output  1  head frame present on out_left/out_right.
REQ-009 out_ready  input  1  consumer accepts head frame when high with out_valid.
REQ-010 out_left  output  WIDTH  head frame left word.
REQ-011 out_right  output  WIDTH  head frame right word.
REQ-012 level  output  clog2(DEPTH)+1  number of stored frames.
REQ-013 overflow  output  1  sticky flag: a frame was dropped.
REQ-014 overflow_clr  input  1  clears overflow.

Function
REQ-015 lrclk_q SHALL register i2s_lrclk every cycle; the frame strobe SHALL be lrclk_q=1 AND i2s_lrclk=0, i.e. the right-to-left boundary.
REQ-016 On a strobe, the block SHALL capture {left_data_in, right_data_in} as one frame; the upstream guarantees both words are stable on that edge.
REQ-017 The first strobe after reset SHALL be discarded, because that frame is partial; a discard_first flag is armed by reset and cleared by that strobe.
REQ-018 Push: a captured frame SHALL be written when level < DEPTH.
REQ-019 Pop: a frame SHALL be removed when out_valid AND out_ready are both high on a rising edge.
REQ-020 Latency: out_valid SHALL rise on the edge after the strobe edge that pushes into an empty FIFO, i.e. one cycle.
REQ-021 out_left/out_right SHALL show the oldest frame whenever out_valid=1, and SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 Ordering SHALL be strict FIFO; the read and write pointers wrap modulo DEPTH with no gap or duplicate at wrap.
REQ-023 When full and there is no pop, a strobe frame SHALL be dropped, existing contents SHALL be unchanged, and overflow SHALL be set the next cycle.
REQ-024 When full with a simultaneous pop and strobe, both SHALL occur, level SHALL stay DEPTH, and overflow SHALL not be set.
REQ-025 When empty, a strobe SHALL not pop in the same cycle; the frame is held per REQ-020.
REQ-026 level SHALL update the cycle after the edge: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-027 If overflow_clr and an overflow event coincide, overflow SHALL end at 1.
REQ-028 Out-of-range out_ready while out_valid=0 SHALL be ignored.

Reset
REQ-029 While reset=1: out_valid=0, level=0, overflow=0, out_left=out_right=0, lrclk_q=0, pointers=0, discard_first=1.
REQ-030 Reset mid-operation SHALL flush all stored frames, and SHALL suppress a strobe on the reset edge.
REQ-031 The first strobe after reset deasserts SHALL obey REQ-017.

Structure
REQ-032 Package i2s_pkg SHALL hold I2S_WORD_WIDTH (16) and I2S_RX_FIFO_DEPTH (8), shared with i2s_master.
REQ-033 Storage SHALL be one sub-module, sync_fifo: parameterised width 2*WIDTH and DEPTH, first-word-fall-through, with full/empty/level outputs.
REQ-034 The top level SHALL contain only the edge detect, discard logic, overflow flag and wiring.

Verification
REQ-035 Apply reset, then 4 lrclk frames with pairs (L,R) 55AA/AA55, 1111/7777, 2222/8888, 3333/9999, with out_ready=1 -> first frame dropped; out frames in order 1111/7777, 2222/8888, 3333/9999, each out_valid one cycle after its strobe.
REQ-036 out_ready=0, then DEPTH+2 frames after the discard -> level=8, overflow=1, the last 2 frames absent; set out_ready=1 -> 8 frames drain in order, then out_valid=0.
REQ-037 FIFO full, out_ready=1 pulsed exactly on a strobe edge -> level stays 8, overflow stays 0, the new frame appears last.
REQ-038 Pulse reset at bclk period 66 with 3 frames stored -> next cycle level=0, out_valid=0; the next strobe is discarded, and the one after is delivered.
REQ-039 Drive 20 frames at 32 bclk/frame with out_ready toggling every cycle -> no loss, no duplication across pointer wrap, level never exceeds 2.
REQ-040 Assert overflow_clr while overflowed with no new drop -> overflow=0 next cycle; with a coincident drop -> overflow=1.

Source files
------------

// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared I2S word/FIFO sizing and frame-boundary helper
package i2s_pkg;

  localparam int I2S_WORD_WIDTH    = 16;
  localparam int I2S_RX_FIFO_DEPTH = 8;

  // A stereo frame ends where word select falls from right (1) back to left (0).
  function automatic logic frame_strobe(input logic lrclk_prev, input logic lrclk_cur);
    return lrclk_prev & ~lrclk_cur;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock first-word-fall-through FIFO with full/empty/level
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LEVEL_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_wr, do_rd;

  always_comb begin
    empty = (level_q == '0);
    full  = (level_q == LEVEL_FULL);
    do_rd = rd_en && !empty;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    do_wr = wr_en && (!full || do_rd);

    mem_d = mem_q;
    if (do_wr) begin
      mem_d[wr_ptr_q] = wr_data;
    end

    wr_ptr_d = wr_ptr_q + AW'(do_wr);
    rd_ptr_d = rd_ptr_q + AW'(do_rd);

    level_d = level_q;
    case ({do_wr, do_rd})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    rd_data = empty ? '0 : mem_q[rd_ptr_q];
    level   = level_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/i2s_rx_sample_fifo.sv
// rtl/i2s_rx_sample_fifo.sv - captures I2S stereo frames into a FIFO with overflow tracking
module i2s_rx_sample_fifo
  import i2s_pkg::*;
#(
  parameter int DEPTH = I2S_RX_FIFO_DEPTH,
  parameter int WIDTH = I2S_WORD_WIDTH
) (
  input  logic                   i2s_bclk,
  input  logic                   reset,
  input  logic                   i2s_lrclk,
  input  logic [WIDTH-1:0]       left_data_in,
  input  logic [WIDTH-1:0]       right_data_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_left,
  output logic [WIDTH-1:0]       out_right,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   overflow_clr
);

  logic                 lrclk_q, lrclk_d;
  logic                 discard_first_q, discard_first_d;
  logic                 overflow_q, overflow_d;
  logic                 strobe, capture, pop, drop;
  logic                 fifo_full, fifo_empty;
  logic [2*WIDTH-1:0]   head;

  always_comb begin
    strobe  = frame_strobe(lrclk_q, i2s_lrclk);
    // The frame in flight when reset releases is incomplete, so its strobe is swallowed.
    capture = strobe && !discard_first_q;
    pop     = !fifo_empty && out_ready;
    drop    = capture && fifo_full && !pop;

    lrclk_d         = i2s_lrclk;
    discard_first_d = discard_first_q && !strobe;

    overflow_d = overflow_q;
    if (overflow_clr) begin
      overflow_d = 1'b0;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge i2s_bclk) begin
    if (reset) begin
      lrclk_q         <= 1'b0;
      discard_first_q <= 1'b1;
      overflow_q      <= 1'b0;
    end else begin
      lrclk_q         <= lrclk_d;
      discard_first_q <= discard_first_d;
      overflow_q      <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH (2 * WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (i2s_bclk),
    .reset   (reset),
    .wr_en   (capture),
    .wr_data ({left_data_in, right_data_in}),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  assign out_valid = !fifo_empty;
  assign out_left  = head[2*WIDTH-1:WIDTH];
  assign out_right = head[WIDTH-1:0];
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_i2s_rx_sample_fifo.sv
// tb/tb_i2s_rx_sample_fifo.sv - directed and randomized bench with a queue-based frame model
module tb_i2s_rx_sample_fifo;

  localparam int D = 8;
  localparam int W = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            lr = 1'b0;
  logic [W-1:0]    ldat = '0;
  logic [W-1:0]    rdat = '0;
  logic            rdy = 1'b0;
  logic            ovclr = 1'b0;
  logic            out_valid;
  logic [W-1:0]    out_left, out_right;
  logic [$clog2(D):0] level;
  logic            overflow;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int maxlvl = 0;
  bit tog = 0;
  bit rnd = 0;

  logic [2*W-1:0] mq[$];
  logic [2*W-1:0] obs[$];
  logic [2*W-1:0] expq[$];
  bit m_ov = 0;
  bit m_disc = 1;
  bit m_prev = 0;

  i2s_rx_sample_fifo #(.DEPTH(D), .WIDTH(W)) dut (
    .i2s_bclk      (clk),
    .reset         (rst),
    .i2s_lrclk     (lr),
    .left_data_in  (ldat),
    .right_data_in (rdat),
    .out_valid     (out_valid),
    .out_ready     (rdy),
    .out_left      (out_left),
    .out_right     (out_right),
    .level         (level),
    .overflow      (overflow),
    .overflow_clr  (ovclr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  // One bclk cycle: advance the frame model on the current inputs, clock, then compare.
  task automatic step();
    bit strobe, cap, pop, room;
    if (!rst && out_valid === 1'b1 && rdy === 1'b1) obs.push_back({out_left, out_right});
    if (rst) begin
      mq.delete();
      m_ov = 0;
      m_disc = 1;
      m_prev = 0;
    end else begin
      strobe = m_prev && !lr;
      cap = strobe && !m_disc;
      if (strobe) m_disc = 0;
      pop = (mq.size() > 0) && rdy;
      room = (mq.size() < D) || pop;
      if (pop) void'(mq.pop_front());
      if (cap && room) mq.push_back({ldat, rdat});
      if (ovclr) m_ov = 0;
      if (cap && !room) m_ov = 1;
      m_prev = lr;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (tog) rdy = ~rdy;
    if (rnd) begin
      rdy = 1'($urandom_range(0, 1));
      ovclr = ($urandom_range(0, 15) == 0);
    end
    if (int'(level) > maxlvl) maxlvl = int'(level);
    chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    chk("level", 64'(level), 64'(mq.size()));
    chk("overflow", 64'(overflow), 64'(m_ov));
    chk("out_left", 64'(out_left), 64'((mq.size() != 0) ? mq[0][2*W-1:W] : '0));
    chk("out_right", 64'(out_right), 64'((mq.size() != 0) ? mq[0][W-1:0] : '0));
  endtask

  // Right half first, then the left half carrying the frame words; the strobe lands on the first low cycle.
  task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r, input int h,
                            input bit pulse_rdy, input bit pulse_clr);
    logic saved_rdy;
    lr = 1'b1;
    ldat = W'($urandom);
    rdat = W'($urandom);
    repeat (h) step();
    lr = 1'b0;
    ldat = l;
    rdat = r;
    saved_rdy = rdy;
    if (pulse_rdy) rdy = 1'b1;
    if (pulse_clr) ovclr = 1'b1;
    step();
    if (pulse_rdy) rdy = saved_rdy;
    if (pulse_clr) ovclr = 1'b0;
    repeat (h - 1) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    lr = 1'b0;
    step();
    step();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_out", 64'({out_left, out_right}), 64'd0);
    rst = 1'b0;
  endtask

  initial begin
    logic [2*W-1:0] f;
    logic [2*W-1:0] newf;

    do_reset();

    // Basic capture with the first partial frame discarded.
    rdy = 1'b1;
    obs.delete();
    send_frame(16'h55AA, 16'hAA55, 4, 0, 0);
    send_frame(16'h1111, 16'h7777, 4, 0, 0);
    send_frame(16'h2222, 16'h8888, 4, 0, 0);
    send_frame(16'h3333, 16'h9999, 4, 0, 0);
    repeat (4) step();
    chk("basic_count", 64'(obs.size()), 64'd3);
    if (obs.size() == 3) begin
      chk("basic_f0", 64'(obs[0]), 64'h1111_7777);
      chk("basic_f1", 64'(obs[1]), 64'h2222_8888);
      chk("basic_f2", 64'(obs[2]), 64'h3333_9999);
    end

    // Overflow: DEPTH+2 frames with the consumer stalled.
    rdy = 1'b0;
    for (int i = 0; i < D + 2; i++) send_frame(16'hA000 + 16'(i), 16'hB000 + 16'(i), 3, 0, 0);
    chk("ovf_level", 64'(level), 64'(D));
    chk("ovf_flag", 64'(overflow), 64'd1);
    rdy = 1'b1;
    obs.delete();
    repeat (D + 2) step();
    chk("ovf_drain_count", 64'(obs.size()), 64'(D));
    for (int i = 0; i < D && i < obs.size(); i++)
      chk("ovf_drain_order", 64'(obs[i]), 64'({16'hA000 + 16'(i), 16'hB000 + 16'(i)}));
    chk("ovf_drain_empty", 64'(out_valid), 64'd0);

    // Clear with no coincident drop.
    ovclr = 1'b1;
    step();
    ovclr = 1'b0;
    chk("ovclr_plain", 64'(overflow), 64'd0);

    // Full FIFO, pop exactly on the strobe edge.
    rdy = 1'b0;
    for (int i = 0; i < D; i++) send_frame(16'hC000 + 16'(i), 16'hD000 + 16'(i), 3, 0, 0);
    obs.delete();
    newf = {16'hE5E5, 16'h5E5E};
    send_frame(newf[2*W-1:W], newf[W-1:0], 3, 1, 0);
    chk("fullpop_level", 64'(level), 64'(D));
    chk("fullpop_ovf", 64'(overflow), 64'd0);
    rdy = 1'b1;
    repeat (D + 2) step();
    chk("fullpop_count", 64'(obs.size()), 64'(D + 1));
    if (obs.size() == D + 1) begin
      chk("fullpop_first", 64'(obs[0]), 64'({16'hC000, 16'hD000}));
      chk("fullpop_last", 64'(obs[D]), 64'(newf));
    end

    // Clear coinciding with a drop keeps the flag set.
    rdy = 1'b0;
    for (int i = 0; i < D; i++) send_frame(16'(i), 16'(i), 2, 0, 0);
    send_frame(16'hFFFF, 16'hFFFF, 2, 0, 1);
    chk("ovclr_drop", 64'(overflow), 64'd1);
    chk("ovclr_drop_level", 64'(level), 64'(D));
    ovclr = 1'b1;
    step();
    ovclr = 1'b0;

    // Reset mid-operation with three frames stored.
    do_reset();
    cyc = 0;
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) send_frame(16'h4000 + 16'(i), 16'h4100 + 16'(i), 8, 0, 0);
    lr = 1'b1;
    while (cyc < 65) step();
    chk("midrst_pre_level", 64'(level), 64'd3);
    rst = 1'b1;
    lr = 1'b0;
    step();
    rst = 1'b0;
    chk("midrst_level", 64'(level), 64'd0);
    chk("midrst_valid", 64'(out_valid), 64'd0);
    rdy = 1'b1;
    obs.delete();
    send_frame(16'h6111, 16'h6222, 4, 0, 0);
    send_frame(16'h6333, 16'h6444, 4, 0, 0);
    repeat (3) step();
    chk("midrst_count", 64'(obs.size()), 64'd1);
    if (obs.size() == 1) chk("midrst_frame", 64'(obs[0]), 64'h6333_6444);

    // Long run across pointer wrap with out_ready toggling every cycle.
    do_reset();
    rdy = 1'b0;
    tog = 1;
    maxlvl = 0;
    obs.delete();
    expq.delete();
    send_frame(16'h0BAD, 16'h0BAD, 16, 0, 0);
    for (int i = 0; i < 20; i++) begin
      f = $urandom;
      expq.push_back(f);
      send_frame(f[2*W-1:W], f[W-1:0], 16, 0, 0);
    end
    repeat (8) step();
    tog = 0;
    chk("wrap_count", 64'(obs.size()), 64'd20);
    for (int i = 0; i < 20 && i < obs.size(); i++) chk("wrap_order", 64'(obs[i]), 64'(expq[i]));
    chk("wrap_maxlvl_le2", 64'(maxlvl <= 2), 64'd1);

    // Randomized traffic against the model.
    rnd = 1;
    for (int i = 0; i < 60; i++) begin
      f = $urandom;
      send_frame(f[2*W-1:W], f[W-1:0], int'($urandom_range(1, 5)), 0, 0);
    end
    rnd = 0;
    ovclr = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
